// File: rtl/mem_responder.sv
// mem_responder
//   Memory-side responder for the core's 8-bit-address / 16-bit-data bus.
//   Owns a DEPTH x DATA_W RAM and a boot sequencer with three states:
//     CLEAR - zero every word, one per cycle (DEPTH cycles)
//     LOAD  - accept a program image over the load port, word i -> mem[i]
//     RUN   - release the core (cpu_hold low) and serve its reads/writes
//
//   Optional feature (compile-time macro MEM_RESPONDER_WRITE_PROTECT_EN):
//     in RUN, core writes below words_loaded are dropped and set the sticky
//     prot_violation flag. Without the macro every core write lands and
//     prot_violation is tied low.
//
//   Ports
//     clock, reset     : system clock, asynchronous active-high reset
//     cpu_address      : core address (combinational from the core)
//     cpu_write        : core write enable, sampled at posedge
//     cpu_data_in      : core write data
//     cpu_data_out     : read data, mem[registered address]; 0 outside RUN
//     cpu_hold         : 1 = core held, 0 = core runs
//     load_valid/ready : load handshake (see below)
//     load_data        : image word
//     load_last        : marks the final image word
//     words_loaded     : number of image words written (0..DEPTH)
//     prot_violation   : sticky write-protect violation flag
//
//   Load handshake: a word transfers on every rising clock edge where
//   load_valid and load_ready are both high. load_ready is high for the
//   whole LOAD state and never depends on load_valid; the loader may hold
//   load_valid low for any number of cycles without losing state.
//
//   DEPTH must equal 2**ADDR_W so addresses wrap with no out-of-range case.

module mem_responder #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic              cpu_write,
    input  logic [DATA_W-1:0] cpu_data_in,
    output logic [DATA_W-1:0] cpu_data_out,
    output logic              cpu_hold,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic [ADDR_W:0]   words_loaded,
    output logic              prot_violation
);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_ptr_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W:0]     words_loaded_q;
    logic                load_accept;

    // Single RAM write port, shared by the clear sweep, the loader and the core.
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   mem [DEPTH];

`ifdef MEM_RESPONDER_WRITE_PROTECT_EN
    logic                cpu_wr_blocked;
    logic                prot_q;
`endif

    // Next-state, handshake and RAM write-port control.
    always_comb begin
        state_d     = state_q;
        cpu_hold    = 1'b1;
        load_ready  = 1'b0;
        load_accept = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = clr_ptr_q;
        mem_wdata   = '0;
`ifdef MEM_RESPONDER_WRITE_PROTECT_EN
        cpu_wr_blocked = 1'b0;
`endif
        case (state_q)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_ptr_q;
                if (clr_ptr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                load_ready = 1'b1;
                mem_waddr  = words_loaded_q[ADDR_W-1:0];
                mem_wdata  = load_data;
                if (load_valid) begin
                    load_accept = 1'b1;
                    mem_we      = 1'b1;
                    // The word being accepted is the last one either when the
                    // loader says so or when it fills the final RAM slot.
                    if (load_last || (words_loaded_q[ADDR_W-1:0] == {ADDR_W{1'b1}})) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                cpu_hold  = 1'b0;
                mem_waddr = cpu_address;
                mem_wdata = cpu_data_in;
`ifdef MEM_RESPONDER_WRITE_PROTECT_EN
                if (cpu_write) begin
                    if ({1'b0, cpu_address} < words_loaded_q) begin
                        cpu_wr_blocked = 1'b1;
                    end else begin
                        mem_we = 1'b1;
                    end
                end
`else
                mem_we = cpu_write;
`endif
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    // Control registers; RAM contents are deliberately not reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= ST_CLEAR;
            clr_ptr_q      <= '0;
            words_loaded_q <= '0;
            addr_q         <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_CLEAR) begin
                clr_ptr_q <= clr_ptr_q + 1'b1;
            end
            if (load_accept) begin
                words_loaded_q <= words_loaded_q + 1'b1;
            end
            // Address only tracks the core once it runs, so the first fetch
            // after release reads address 0.
            if (state_q == ST_RUN) begin
                addr_q <= cpu_address;
            end
        end
    end

`ifdef MEM_RESPONDER_WRITE_PROTECT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prot_q <= 1'b0;
        end else if (cpu_wr_blocked) begin
            prot_q <= 1'b1;
        end
    end
    assign prot_violation = prot_q;
`else
    assign prot_violation = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Read through the registered address: a write to the same address at
    // the same edge is visible here in the following cycle.
    assign cpu_data_out = (state_q == ST_RUN) ? mem[addr_q] : '0;
    assign words_loaded = words_loaded_q;

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the 8-bit-address / 16-bit-data single-port bus driven by the processor core.
- Owns a 256x16 synchronous RAM and returns read data one registered-address cycle after presentation, matching the core's fetch/decode/execute timing.
- Contains a boot sequencer: clears the RAM, accepts a program image over a valid/ready load port, then releases the core via cpu_hold.
- Replaces the init-file approach, so programs can be reloaded without resynthesis.

Parameters:
DATA_W, 16, data word width
ADDR_W, 8, address width
DEPTH, 256, number of words; must equal 2**ADDR_W

Ports:
clock  input  1  system clock
reset  input  1  reset, asynchronous, active-high
cpu_address  input  ADDR_W  core memory address, combinational from the core
cpu_write  input  1  core write enable, sampled at posedge
cpu_data_in  input  DATA_W  core write data (register_A)
cpu_data_out  output  DATA_W  read data to the core
cpu_hold  output  1  high = core must be held in reset/stall; low = RUN
load_valid  input  1  loader word valid
load_ready  output  1  responder accepts a load word this cycle
load_data  input  DATA_W  program/data word
load_last  input  1  qualifies the final load word
words_loaded  output  ADDR_W+1  count of words written during LOAD (0..256)
prot_violation  output  1  sticky write-protect flag (see Optional Feature)

Behaviour:
- Reset values (asynchronous): state=CLEAR, clear pointer=0, words_loaded=0, cpu_hold=1, load_ready=0, cpu_data_out=0, prot_violation=0, registered address=0.
- RAM contents are not reset asynchronously. Contents are defined only after CLEAR completes.
- The state machine has three states: CLEAR, LOAD, RUN.
- CLEAR:
  - Writes 0 to mem[ptr] each cycle, ptr=0..255, taking exactly 256 cycles.
  - After the write to 255, goes to LOAD.
  - load_ready=0; CPU inputs ignored.
- LOAD:
  - load_ready=1.
  - On (load_valid & load_ready), writes mem[words_loaded]=load_data and increments words_loaded.
  - Goes to RUN in the cycle after the accepted word with load_last=1, or after the 256th word even if load_last=0.
  - load_valid=0 holds the state indefinitely.
  - load_valid with load_last while words_loaded=0 writes address 0 and finishes with words_loaded=1.
- RUN:
  - cpu_hold=0 and load_ready=0; load_valid is ignored.
  - Core access at posedge: registered address <= cpu_address. If cpu_write, mem[cpu_address] <= cpu_data_in.
  - cpu_data_out = mem[registered address], an unregistered output of the registered address. Latency is one clock from address presentation.
  - Read-during-write to the same address returns the NEW data in the following cycle.
  - cpu_write held high over consecutive cycles (e.g. the core's store/store2 states) writes each cycle; the last value wins.
- cpu_data_out = 0 in CLEAR and LOAD.
- cpu_hold deasserts in the same edge that enters RUN. The core's first fetch sees address 0 valid one cycle later.
- Reset mid-CLEAR or mid-LOAD: restarts at CLEAR with ptr=0 and words_loaded=0; partial image is discarded.
- Reset in RUN: cpu_hold reasserts immediately (async); full clear/load repeats.
- Addresses wrap naturally at ADDR_W bits; no out-of-range case exists.

Optional Feature:
- Macro: MEM_RESPONDER_WRITE_PROTECT_EN.
- Defined:
  - In RUN, a core write with cpu_address < words_loaded is suppressed; RAM is unchanged.
  - The suppressed write sets prot_violation, which stays set until reset.
  - Reads are unaffected.
- Not defined:
  - All core writes succeed.
  - prot_violation is tied 0. The port remains present for both builds.

Test Plan:
- Clear timing: assert/release reset, keep load_valid=0 → load_ready rises exactly 256 cycles after reset release; cpu_hold=1 throughout; cpu_data_out=0.
- Load with last: load words 0x0205, 0x0006, 0x0100 (load_last on the third), with one idle cycle between words → words_loaded=3; RUN entered the next cycle; cpu_hold=0; reading addr 1 returns 0x0006 one cycle later; addr 3 returns 0x0000.
- Full image: 256 words 0x1000+i, load_last never asserted → RUN after word 255; words_loaded=256; addr 0xFF reads 0x10FF.
- RUN write/read: write addr 0x20 = 0xBEEF with cpu_write high for 2 cycles, then read 0x20 → cpu_data_out=0xBEEF one cycle after address; same-address read-during-write shows 0xBEEF the next cycle.
- Reset mid-LOAD after 2 words → words_loaded=0; cpu_hold=1; the next LOAD starts at address 0 and prior words read 0 after the reload.
- Write protect (macro defined): words_loaded=3; write 0x1234 to addr 2 → addr 2 unchanged; prot_violation=1 and sticky. Write to addr 3 succeeds. Macro undefined: addr 2 becomes 0x1234 and prot_violation stays 0.
